// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, waits out the fixed imem read latency, and presents
// fetched words to decode over valid/ready. Redirects reload the PC; illegal fetches trap to a sticky fault.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h00400000,
    parameter logic [31:0] TEXT_LIMIT  = 32'h0040007C,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_plus4,
    output logic        fault,
    output logic [31:0] fault_pc
);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_FAULT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   pc;
    logic          pc_illegal;
    logic          out_free;
    logic          xfer;

    assign imem_addr  = pc;
    assign pc_illegal = (pc[1:0] != 2'b00) || pc[31] || (pc < RESET_PC) || (pc > TEXT_LIMIT);
    assign out_free   = !inst_valid || inst_ready;
    assign xfer       = inst_valid && inst_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_ISSUE;
            cnt        <= '0;
            pc         <= RESET_PC;
            inst_valid <= 1'b0;
            inst_out   <= '0;
            inst_pc    <= '0;
            pc_plus4   <= '0;
            fault      <= 1'b0;
            fault_pc   <= '0;
        end else begin
            case (state)
                S_FAULT: begin
                    inst_valid <= 1'b0;
                end
                default: begin
                    if (redirect_valid) begin
                        // Flush wins over a same-edge handshake or capture.
                        pc         <= redirect_target;
                        state      <= S_ISSUE;
                        inst_valid <= 1'b0;
                    end else if (state == S_ISSUE) begin
                        if (pc_illegal) begin
                            state      <= S_FAULT;
                            fault      <= 1'b1;
                            fault_pc   <= pc;
                            inst_valid <= 1'b0;
                        end else begin
                            cnt   <= CW'(WAIT_CYCLES - 1);
                            state <= S_WAIT;
                            if (xfer) inst_valid <= 1'b0;
                        end
                    end else if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                        if (xfer) inst_valid <= 1'b0;
                    end else if (out_free) begin
                        inst_out   <= imem_data;
                        inst_pc    <= pc;
                        pc_plus4   <= pc + 32'd4;
                        inst_valid <= 1'b1;
                        pc         <= pc + 32'd4;
                        state      <= S_ISSUE;
                    end
                    // Otherwise stalled with data ready: hold PC and outputs.
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against an address-age reference model.
module tb_fetch_unit;
    localparam logic [31:0] RPC  = 32'h00400000;
    localparam logic [31:0] TLIM = 32'h0040007C;
    localparam int          W    = 2;
    localparam logic [31:0] KEY  = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_addr, imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        inst_ready = 1'b0;
    logic        inst_valid, fault;
    logic [31:0] inst_out, inst_pc, pc_plus4, fault_pc;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    fetch_unit #(.RESET_PC(RPC), .TEXT_LIMIT(TLIM), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .inst_ready(inst_ready), .inst_valid(inst_valid), .inst_out(inst_out),
        .inst_pc(inst_pc), .pc_plus4(pc_plus4), .fault(fault), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;
    assign imem_data = imem_addr ^ KEY;

    // Model: m_age counts edges the current address has been held; 0 means the legality check is due.
    logic [31:0] m_pc, m_out, m_ipc, m_p4, m_fpc;
    logic        m_valid, m_fault;
    int          m_age;

    function automatic bit illegal(input logic [31:0] a);
        return (a[1:0] != 2'b00) || a[31] || (a < RPC) || (a > TLIM);
    endfunction

    task automatic model_reset();
        m_pc = RPC; m_age = 0; m_valid = 0; m_out = 0; m_ipc = 0; m_p4 = 0;
        m_fault = 0; m_fpc = 0;
    endtask

    task automatic model_step();
        bit took;
        took = m_valid && inst_ready;
        if (m_fault) begin
            m_valid = 0;
        end else if (redirect_valid) begin
            m_pc = redirect_target; m_age = 0; m_valid = 0;
        end else if (m_age == 0 && illegal(m_pc)) begin
            m_fault = 1; m_fpc = m_pc; m_valid = 0;
        end else if (m_age < W) begin
            m_age++;
            if (took) m_valid = 0;
        end else if (!m_valid || inst_ready) begin
            m_out = m_pc ^ KEY; m_ipc = m_pc; m_p4 = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4; m_age = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("inst_valid", 32'(inst_valid), 32'(m_valid));
            chk("inst_out", inst_out, m_out);
            chk("inst_pc", inst_pc, m_ipc);
            chk("pc_plus4", pc_plus4, m_p4);
            chk("fault", 32'(fault), 32'(m_fault));
            chk("fault_pc", fault_pc, m_fpc);
        end
    end

    task automatic cyc(input logic rv, input logic [31:0] rt, input logic rdy);
        redirect_valid = rv; redirect_target = rt; inst_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        redirect_valid = 0; inst_ready = 0;
        reset = 1;
        model_reset();
        #1;
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        #1;
        reset = 0;
    endtask

    logic [31:0] bad_t[3];

    initial begin
        bad_t[0] = 32'h00400080; bad_t[1] = 32'h00400042; bad_t[2] = 32'h80400000;
        do_reset();
        cmp_en = 1;

        // Scenario 1: first delivery after edge 3, then every 3 cycles.
        repeat (2) cyc(0, 0, 1);
        chk("s1_not_yet", 32'(inst_valid), 32'd0);
        cyc(0, 0, 1);
        chk("s1_valid", 32'(inst_valid), 32'd1);
        chk("s1_pc", inst_pc, 32'h00400000);
        chk("s1_p4", pc_plus4, 32'h00400004);
        chk("s1_data", inst_out, 32'hA5E5A5A5);
        repeat (3) cyc(0, 0, 1);
        chk("s1_pc2", inst_pc, 32'h00400004);

        // Scenario 2: backpressure stall, then transfer + capture on the same edge.
        @(posedge clk); #1;
        do_reset();
        repeat (3) cyc(0, 0, 1);
        repeat (10) cyc(0, 0, 0);
        chk("s2_hold_pc", inst_pc, 32'h00400000);
        chk("s2_hold_valid", 32'(inst_valid), 32'd1);
        chk("s2_addr", imem_addr, 32'h00400004);
        cyc(0, 0, 1);
        chk("s2_next_pc", inst_pc, 32'h00400004);
        chk("s2_next_valid", 32'(inst_valid), 32'd1);

        // Scenario 3: redirect during WAIT while holding an instruction.
        cyc(0, 0, 0);
        cyc(1, 32'h00400040, 0);
        chk("s3_flush", 32'(inst_valid), 32'd0);
        repeat (3) cyc(0, 0, 1);
        chk("s3_pc", inst_pc, 32'h00400040);
        chk("s3_valid", 32'(inst_valid), 32'd1);

        // Scenario 4: illegal redirect targets trap; later redirects ignored.
        for (int i = 0; i < 3; i++) begin
            do_reset();
            cyc(0, 0, 1);
            cyc(1, bad_t[i], 1);
            cyc(0, 0, 1);
            chk("s4_fault", 32'(fault), 32'd1);
            chk("s4_fault_pc", fault_pc, bad_t[i]);
            cyc(1, RPC, 1);
            repeat (4) cyc(0, 0, 1);
            chk("s4_frozen", imem_addr, bad_t[i]);
            chk("s4_novalid", 32'(inst_valid), 32'd0);
        end

        // Scenario 5: last text word delivered, then fall-through faults.
        do_reset();
        cyc(1, TLIM, 1);
        repeat (3) cyc(0, 0, 1);
        chk("s5_pc", inst_pc, TLIM);
        chk("s5_p4", pc_plus4, 32'h00400080);
        cyc(0, 0, 1);
        chk("s5_fault", 32'(fault), 32'd1);
        chk("s5_fault_pc", fault_pc, 32'h00400080);

        // Scenario 6: async reset mid-stall, then normal restart.
        do_reset();
        repeat (3) cyc(0, 0, 1);
        repeat (5) cyc(0, 0, 0);
        #1;
        do_reset();
        repeat (3) cyc(0, 0, 1);
        chk("s6_pc", inst_pc, RPC);
        chk("s6_valid", 32'(inst_valid), 32'd1);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            logic        rv, rdy;
            logic [31:0] t;
            int          r;
            if ($urandom_range(0, 299) == 0) do_reset();
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 19) == 0);
            r   = $urandom_range(0, 9);
            if (r < 7)       t = RPC + (32'($urandom_range(0, 31)) << 2);
            else if (r == 7) t = TLIM - (32'($urandom_range(0, 2)) << 2);
            else if (r == 8) t = 32'($urandom());
            else             t = RPC + 32'($urandom_range(0, 140));
            cyc(rv, t, rdy);
        end

        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the memory address. It waits out the memory's fixed read latency, then latches the returned word into an output register that the decode stage consumes via a valid/ready handshake. Branch/jump redirects come in from downstream, and illegal fetch addresses are trapped as a sticky fault.

Parameters:
RESET_PC, 32'h00400000, PC value after reset; also the lowest legal fetch address.
TEXT_LIMIT, 32'h0040007C, highest legal fetch address (last word of 32-word text segment).
WAIT_CYCLES, 2, full clock cycles the address is held before imem_data is sampled; must be >= 1.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
imem_addr  output  32  current PC; drives instruction memory address_in.
imem_data  input  32  instruction word returned by instruction memory.
redirect_valid  input  1  one-cycle pulse: load redirect_target into PC.
redirect_target  input  32  new PC for branch/jump/jr.
inst_ready  input  1  decode accepts inst_out this cycle.
inst_valid  output  1  inst_out/inst_pc/pc_plus4 hold a valid instruction.
inst_out  output  32  latched instruction word.
inst_pc  output  32  address inst_out was fetched from.
pc_plus4  output  32  inst_pc + 4 (modulo 2^32).
fault  output  1  sticky illegal-fetch flag.
fault_pc  output  32  PC that caused the fault.

Behaviour:
- Reset (async, immediate, no clock edge needed):
  - PC/imem_addr = RESET_PC.
  - inst_valid = 0; inst_out, inst_pc, pc_plus4 = 0.
  - fault = 0; fault_pc = 0.
  - state = ISSUE; wait counter = 0.
  - Reset asserted mid-operation discards any pending or held instruction.
- States: ISSUE, WAIT, FAULT.
- ISSUE (one cycle):
  - PC is illegal if PC[1:0] != 0, PC[31] = 1, PC < RESET_PC, or PC > TEXT_LIMIT.
  - Illegal: next state FAULT; fault <= 1; fault_pc <= PC.
  - Legal: counter <= WAIT_CYCLES-1; next state WAIT.
- WAIT:
  - Counter != 0: decrement.
  - Counter == 0 and output free (!inst_valid || inst_ready): capture on this edge.
    - inst_out <= imem_data; inst_pc <= PC; pc_plus4 <= PC+4; inst_valid <= 1.
    - PC <= PC+4; next state ISSUE.
  - Counter == 0 and output not free: remain in WAIT with counter at 0; PC and imem_addr held stable (stall, no lost instruction).
- Handshake:
  - Transfer occurs when inst_valid && inst_ready.
  - After a transfer with no simultaneous capture, inst_valid <= 0.
  - While inst_valid=1 and inst_ready=0, inst_out/inst_pc/pc_plus4 must not change.
- Latency and throughput: after reset release, inst_valid first rises after edge 1+WAIT_CYCLES; without backpressure, one instruction every 1+WAIT_CYCLES cycles.
- Redirect:
  - Takes priority over everything except reset and FAULT.
  - On an edge with redirect_valid=1: PC <= redirect_target; state <= ISSUE; inst_valid <= 0.
  - A capture due on the same edge is suppressed.
  - A concurrent inst_ready is not a transfer; the held instruction is flushed.
- FAULT:
  - Terminal until reset. inst_valid = 0; redirect_valid ignored; PC frozen; fault and fault_pc stable.
  - No fault is raised for the instruction already delivered.
- End of text: the word at TEXT_LIMIT is fetched and delivered normally. The following sequential ISSUE at TEXT_LIMIT+4 faults.
- Arithmetic: all PC math is 32-bit unsigned with wrap. A wrapped PC is caught by the range check.

Test Plan:
1. Reset release, WAIT_CYCLES=2, memory model returning data = address XOR 32'hA5A5A5A5, inst_ready=1 -> inst_valid rises after edge 3 with inst_pc=0x00400000, pc_plus4=0x00400004; next instruction at inst_pc=0x00400004 three cycles later.
2. Hold inst_ready=0 for 10 cycles after first capture -> inst_out/inst_pc unchanged, imem_addr steady at 0x00400004. On release: 0x00400000 transfers, then 0x00400004 is captured on that same edge; no gaps or duplicates.
3. Pulse redirect_valid with target 0x00400040 during WAIT while inst_valid=1 -> inst_valid=0 next cycle; next delivered inst_pc=0x00400040 after a further 3 edges.
4. Redirect to 0x00400080 -> fault=1, fault_pc=0x00400080, inst_valid stays 0. Subsequent redirect to 0x00400000 ignored. Repeat after reset with 0x00400042 (misaligned) and 0x80400000 -> same fault behaviour.
5. Redirect to 0x0040007C -> that word delivered with pc_plus4=0x00400080; fault then rises with fault_pc=0x00400080.
6. Assert reset between clock edges during a backpressure stall -> all outputs return to reset values before the next edge; after release, fetch restarts at 0x00400000 with the latency of scenario 1.
